usb_pd_tx_ctrl: RTL and testbench

Protocol-layer transmit controller sitting directly upstream of the PD PHY transmitter (`usb_pd_phy_wr`). It accepts one message request at a time, stamps it with the MessageID counter, and fires the PHY. After each non-hard-reset transmission it waits for a matching GoodCRC from the receive path, retrying on timeout. It then reports success, failure or hard-reset-sent to the policy engine.

---
 rtl/usb_pd_tx_ctrl.sv | 226 ++++++++++++++++++++++
 tb/tb_usb_pd_tx_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_pd_tx_ctrl.sv
// -----------------------------------------------------------------------------
// usb_pd_tx_ctrl
//
// Protocol-layer transmit controller for USB Power Delivery. Sits directly in
// front of the PD PHY transmitter. The controller:
//   - accepts one message request at a time;
//   - stamps it with the 3-bit MessageID counter;
//   - launches the PHY and waits for the PHY to finish.
// SOP messages then wait for a GoodCRC from the receive path and are retried
// when that wait times out. Hard Reset ordered sets need no GoodCRC and
// complete as soon as the PHY goes idle.
//
// Parameters
//   system_khz          clock frequency in kHz
//   receive_timeout_us  GoodCRC wait window (tReceive) in microseconds
//   n_retry             retransmissions allowed after the first attempt
//
// Ports
//   clock               single clock
//   nrst                synchronous active-low reset
//   req                 request pulse, sampled only while idle
//   req_hrst            1 = Hard Reset ordered set, 0 = SOP message
//   req_num/req_type    data-object count / message type of the request
//   req_words           up to 7 data objects, word k at [32k +: 32]
//   id_rst              clears the MessageID counter (protocol soft reset)
//   busy                high from the cycle after acceptance through done
//   done                one-cycle completion pulse
//   result              0 GoodCRC, 1 retries exhausted, 2 hard reset sent
//   phy_start           one-cycle start pulse to the PHY
//   phy_busy            PHY transmitter busy
//   phy_hrst/phy_id/phy_num/phy_type/phy_words
//                       latched header/payload fields presented to the PHY
//   rx_valid            one-cycle pulse marking a received message
//   rx_num/rx_type/rx_id
//                       header fields of that received message
// -----------------------------------------------------------------------------
module usb_pd_tx_ctrl #(
  parameter int system_khz         = 200000,
  parameter int receive_timeout_us = 1000,
  parameter int n_retry            = 2
) (
  input  logic         clock,
  input  logic         nrst,
  input  logic         req,
  input  logic         req_hrst,
  input  logic [2:0]   req_num,
  input  logic [3:0]   req_type,
  input  logic [223:0] req_words,
  input  logic         id_rst,
  output logic         busy,
  output logic         done,
  output logic [1:0]   result,
  output logic         phy_start,
  input  logic         phy_busy,
  output logic         phy_hrst,
  output logic [2:0]   phy_id,
  output logic [2:0]   phy_num,
  output logic [3:0]   phy_type,
  output logic [223:0] phy_words,
  input  logic         rx_valid,
  input  logic [2:0]   rx_num,
  input  logic [3:0]   rx_type,
  input  logic [2:0]   rx_id
);

  // GoodCRC wait window in clock cycles, fixed at elaboration.
  localparam logic [31:0] TIMEOUT_CYC = 32'(system_khz * receive_timeout_us / 1000);

  // Retry counter just wide enough to hold n_retry.
  localparam int RW = (n_retry < 2) ? 1 : $clog2(n_retry + 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(n_retry);

  localparam logic [1:0] RES_GOODCRC = 2'd0;
  localparam logic [1:0] RES_NO_ACK  = 2'd1;
  localparam logic [1:0] RES_HRST    = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LAUNCH    = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_SENDING   = 3'd3,
    S_WAIT_CRC  = 3'd4,
    S_DONE      = 3'd5
  } state_t;

  state_t          r_state;
  logic [2:0]      r_msg_id;
  logic [RW-1:0]   r_retry_cnt;
  logic [31:0]     r_timer;
  logic            r_busy;
  logic            r_done;
  logic [1:0]      r_result;
  logic            r_start;
  logic            r_phy_hrst;
  logic [2:0]      r_phy_id;
  logic [2:0]      r_phy_num;
  logic [3:0]      r_phy_type;
  logic [223:0]    r_phy_words;

  logic            w_good_crc;
  logic            w_expired;
  logic [2:0]      w_id_next;

  // GoodCRC recognition, window expiry and MessageID increment.
  always_comb begin
    w_good_crc = rx_valid && (rx_num == 3'd0) && (rx_type == 4'd1) && (rx_id == r_phy_id);
    // The window closes on the cycle the timer would decrement to zero,
    // so WAIT_CRC lasts exactly TIMEOUT_CYC cycles.
    w_expired  = (r_timer <= 32'd1);
    w_id_next  = r_msg_id + 3'd1;
  end

  // Transmit FSM with all outputs registered.
  always_ff @(posedge clock) begin
    if (!nrst) begin
      r_state     <= S_IDLE;
      r_msg_id    <= 3'd0;
      r_retry_cnt <= '0;
      r_timer     <= 32'd0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_result    <= 2'd0;
      r_start     <= 1'b0;
      r_phy_hrst  <= 1'b0;
      r_phy_id    <= 3'd0;
      r_phy_num   <= 3'd0;
      r_phy_type  <= 4'd0;
      r_phy_words <= 224'd0;
    end else begin
      r_start <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req) begin
            r_phy_hrst  <= req_hrst;
            r_phy_num   <= req_num;
            r_phy_type  <= req_type;
            r_phy_words <= req_words;
            r_phy_id    <= r_msg_id;
            r_retry_cnt <= '0;
            r_busy      <= 1'b1;
            r_start     <= 1'b1;
            r_state     <= S_LAUNCH;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_LAUNCH: begin
          r_state <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          if (phy_busy) begin
            r_state <= S_SENDING;
          end else begin
            r_state <= S_WAIT_BUSY;
          end
        end
        S_SENDING: begin
          if (!phy_busy) begin
            if (r_phy_hrst) begin
              // Hard Reset is never acknowledged and restarts MessageID.
              r_result <= RES_HRST;
              r_msg_id <= 3'd0;
              r_done   <= 1'b1;
              r_state  <= S_DONE;
            end else begin
              r_timer <= TIMEOUT_CYC;
              r_state <= S_WAIT_CRC;
            end
          end else begin
            r_state <= S_SENDING;
          end
        end
        S_WAIT_CRC: begin
          // A GoodCRC in the expiry cycle still counts as success.
          if (w_good_crc) begin
            r_result <= RES_GOODCRC;
            r_msg_id <= w_id_next;
            r_timer  <= 32'd0;
            r_done   <= 1'b1;
            r_state  <= S_DONE;
          end else if (w_expired) begin
            r_timer <= 32'd0;
            if (r_retry_cnt < RETRY_MAX) begin
              // Resend with the same latched id and payload.
              r_retry_cnt <= r_retry_cnt + {{(RW-1){1'b0}}, 1'b1};
              r_start     <= 1'b1;
              r_state     <= S_LAUNCH;
            end else begin
              r_result <= RES_NO_ACK;
              r_msg_id <= w_id_next;
              r_done   <= 1'b1;
              r_state  <= S_DONE;
            end
          end else begin
            r_timer <= r_timer - 32'd1;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
      // Placed last so a clear overrides a same-cycle completion increment.
      // The in-flight r_phy_id is deliberately left alone.
      if (id_rst) begin
        r_msg_id <= 3'd0;
      end
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign result    = r_result;
  assign phy_start = r_start;
  assign phy_hrst  = r_phy_hrst;
  assign phy_id    = r_phy_id;
  assign phy_num   = r_phy_num;
  assign phy_type  = r_phy_type;
  assign phy_words = r_phy_words;

endmodule

// File: tb/tb_usb_pd_tx_ctrl.sv
// -----------------------------------------------------------------------------
// tb_usb_pd_tx_ctrl
//
// Directed bench for usb_pd_tx_ctrl. Timing assumptions:
//   - a 10 us receive window at 200 MHz gives 2000 cycles;
//   - a stub PHY holds phy_busy for B_LEN cycles after each start pulse;
//   - inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_usb_pd_tx_ctrl;

  localparam int T_CYC = 2000;
  localparam int B_LEN = 100;

  logic         clock = 1'b0;
  logic         nrst, req, req_hrst, id_rst;
  logic [2:0]   req_num;
  logic [3:0]   req_type;
  logic [223:0] req_words;
  logic         busy, done, phy_start, phy_busy, phy_hrst;
  logic [1:0]   result;
  logic [2:0]   phy_id, phy_num;
  logic [3:0]   phy_type;
  logic [223:0] phy_words;
  logic         rx_valid;
  logic [2:0]   rx_num, rx_id;
  logic [3:0]   rx_type;

  always #5 clock = ~clock;

  usb_pd_tx_ctrl #(
    .system_khz(200000), .receive_timeout_us(10), .n_retry(2)
  ) dut (
    .clock(clock), .nrst(nrst), .req(req), .req_hrst(req_hrst),
    .req_num(req_num), .req_type(req_type), .req_words(req_words),
    .id_rst(id_rst), .busy(busy), .done(done), .result(result),
    .phy_start(phy_start), .phy_busy(phy_busy), .phy_hrst(phy_hrst),
    .phy_id(phy_id), .phy_num(phy_num), .phy_type(phy_type),
    .phy_words(phy_words), .rx_valid(rx_valid), .rx_num(rx_num),
    .rx_type(rx_type), .rx_id(rx_id)
  );

  // Stub PHY: busy for B_LEN cycles following each start pulse.
  int busy_cnt = 0;
  assign phy_busy = (busy_cnt != 0);
  always @(posedge clock) begin
    if (!nrst) busy_cnt <= 0;
    else if (phy_start) busy_cnt <= B_LEN;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end

  // Start-pulse counter and the cycle stamps of the last two starts.
  int cyc = 0, n_starts = 0, start_prev = 0, start_last = 0;
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (phy_start) begin
      n_starts   <= n_starts + 1;
      start_prev <= start_last;
      start_last <= cyc;
    end
  end

  int total = 0;
  int bad   = 0;
  int base  = 0;
  logic [223:0] words_v;

  task automatic chk(input string tag, input logic [223:0] obs, input logic [223:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  task automatic wait_busy_fall(input string tag);
    int n;
    n = 0;
    while (phy_busy !== 1'b1 && n < 500) begin step(); n++; end
    while (phy_busy !== 1'b0 && n < 1000) begin step(); n++; end
    chk({tag, "_busy_timeout"}, (n >= 1000), 1'b0);
  endtask

  task automatic wait_starts(input string tag, input int target);
    int n;
    n = 0;
    while (n_starts < target && n < 3000) begin step(); n++; end
    chk({tag, "_start_timeout"}, (n >= 3000), 1'b0);
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 8000) begin step(); n++; end
    chk({tag, "_done_timeout"}, (n >= 8000), 1'b0);
  endtask

  task automatic rx_pulse(input logic [2:0] id, input logic [3:0] typ, input logic [2:0] num);
    rx_valid = 1'b1; rx_id = id; rx_type = typ; rx_num = num;
    step();
    rx_valid = 1'b0; rx_id = 3'd0; rx_type = 4'd0; rx_num = 3'd0;
  endtask

  // Issue a request one cycle after the call, then check the start cycle.
  task automatic issue(input logic hrst, input logic [3:0] typ, input logic [2:0] num,
                       input logic [2:0] exp_id, input string tag);
    step();
    req = 1'b1; req_hrst = hrst; req_type = typ; req_num = num;
    step();
    req = 1'b0; req_hrst = 1'b0;
    chk({tag, "_start"}, phy_start, 1'b1);
    chk({tag, "_busy"}, busy, 1'b1);
    chk({tag, "_id"}, phy_id, exp_id);
  endtask

  // Full control-message exchange acknowledged on the first attempt.
  task automatic msg_ok(input logic [3:0] typ, input logic [2:0] exp_id, input string tag);
    issue(1'b0, typ, 3'd0, exp_id, tag);
    chk({tag, "_type"}, phy_type, typ);
    wait_busy_fall(tag);
    repeat (5) step();
    rx_pulse(exp_id, 4'd1, 3'd0);
    chk({tag, "_done"}, done, 1'b1);
    chk({tag, "_result"}, result, 2'd0);
  endtask

  initial begin
    nrst = 1'b0; req = 1'b0; req_hrst = 1'b0; req_num = 3'd0; req_type = 4'd0;
    req_words = 224'd0; id_rst = 1'b0; rx_valid = 1'b0; rx_num = 3'd0;
    rx_type = 4'd0; rx_id = 3'd0;
    repeat (3) step();
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_result", result, 2'd0);
    chk("rst_start", phy_start, 1'b0);
    chk("rst_id", phy_id, 3'd0);
    chk("rst_words", phy_words, 224'd0);
    nrst = 1'b1;

    // Control message with a prompt GoodCRC.
    base = n_starts;
    msg_ok(4'd3, 3'd0, "ctl");
    chk("ctl_nstarts", n_starts - base, 1);
    step();
    chk("ctl_done_pulse", done, 1'b0);
    chk("ctl_busy_end", busy, 1'b0);

    // No GoodCRC: three attempts, B_LEN + T_CYC + 2 cycles apart.
    base = n_starts;
    issue(1'b0, 4'd2, 3'd0, 3'd1, "to");
    wait_starts("to2", base + 2);
    chk("to_space1", start_last - start_prev, B_LEN + T_CYC + 2);
    wait_starts("to3", base + 3);
    chk("to_space2", start_last - start_prev, B_LEN + T_CYC + 2);
    chk("to_id_kept", phy_id, 3'd1);
    wait_done("to");
    chk("to_result", result, 2'd1);
    chk("to_nstarts", n_starts - base, 3);

    // Late GoodCRC on the second attempt; a wrong-id reply is ignored.
    msg_ok(4'd3, 3'd2, "adv2");
    msg_ok(4'd3, 3'd3, "adv3");
    base = n_starts;
    issue(1'b0, 4'd3, 3'd0, 3'd4, "late");
    wait_busy_fall("late1");
    repeat (20) step();
    rx_pulse(3'd5, 4'd1, 3'd0);
    chk("late_ignored", done, 1'b0);
    wait_starts("late", base + 2);
    wait_busy_fall("late2");
    repeat (10) step();
    rx_pulse(3'd4, 4'd1, 3'd0);
    chk("late_done", done, 1'b1);
    chk("late_result", result, 2'd0);
    chk("late_nstarts", n_starts - base, 2);

    // Hard reset with the counter at 6: no GoodCRC wait, counter cleared.
    msg_ok(4'd3, 3'd5, "adv5");
    base = n_starts;
    issue(1'b1, 4'd0, 3'd0, 3'd6, "hr");
    chk("hr_flag", phy_hrst, 1'b1);
    wait_busy_fall("hr");
    step();
    chk("hr_done", done, 1'b1);
    chk("hr_result", result, 2'd2);
    chk("hr_nstarts", n_starts - base, 1);

    // Data message: payload exact, held across a retry, req while busy ignored.
    for (int k = 0; k < 7; k++) words_v[32*k +: 32] = 32'h1111_1111 * (k + 1);
    req_words = words_v;
    base = n_starts;
    issue(1'b0, 4'd1, 3'd7, 3'd0, "data");
    chk("data_num", phy_num, 3'd7);
    chk("data_words", phy_words, words_v);
    req = 1'b1; req_num = 3'd2; req_type = 4'd5; req_words = ~words_v;
    step();
    req = 1'b0; req_words = 224'd0;
    chk("data_busy_req_num", phy_num, 3'd7);
    chk("data_busy_req_type", phy_type, 4'd1);
    wait_starts("data", base + 2);
    chk("data_retry_words", phy_words, words_v);
    chk("data_retry_id", phy_id, 3'd0);
    wait_busy_fall("data");
    repeat (3) step();
    rx_pulse(3'd0, 4'd1, 3'd3);
    chk("data_rx_datamsg_ignored", done, 1'b0);
    rx_pulse(3'd0, 4'd1, 3'd0);
    chk("data_done", done, 1'b1);
    chk("data_result", result, 2'd0);

    // Walk the counter up to 7 and across the wrap.
    for (int k = 1; k < 8; k++) msg_ok(4'd3, 3'(k), "walk");
    msg_ok(4'd3, 3'd0, "wrap");

    // id_rst mid-wait keeps the in-flight id; a same-cycle clear beats the increment.
    issue(1'b0, 4'd3, 3'd0, 3'd1, "idr");
    wait_busy_fall("idr");
    repeat (4) step();
    id_rst = 1'b1;
    step();
    id_rst = 1'b0;
    chk("idr_inflight_id", phy_id, 3'd1);
    repeat (3) step();
    id_rst = 1'b1;
    rx_pulse(3'd1, 4'd1, 3'd0);
    id_rst = 1'b0;
    chk("idr_done", done, 1'b1);
    msg_ok(4'd3, 3'd0, "idr_next");

    // nrst during SENDING: immediate idle with every output cleared.
    issue(1'b0, 4'd6, 3'd0, 3'd1, "nr");
    repeat (5) step();
    nrst = 1'b0;
    step();
    chk("nr_busy", busy, 1'b0);
    chk("nr_start", phy_start, 1'b0);
    chk("nr_id", phy_id, 3'd0);
    chk("nr_type", phy_type, 4'd0);
    chk("nr_words", phy_words, 224'd0);
    step();
    chk("nr_start_held", phy_start, 1'b0);
    nrst = 1'b1;
    msg_ok(4'd3, 3'd0, "nr_next");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
